// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared helpers for the sync_fifo_fwft family:
//   clog2        - ceiling log2 usable in constant expressions
//   calc_aw      - address (pointer) width for a given depth
//   calc_cw      - occupancy counter width (must be able to hold DEPTH itself)
//   is_pow2      - power-of-two test
//   params_ok    - legality of a WIDTH/DEPTH/AFVAL/AEVAL combination
// Optional feature of the FIFO: SYNC_FIFO_STICKY_ERR_EN (see sync_fifo_fwft.sv).
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int MIN_DEPTH = 4;
  localparam int MAX_DEPTH = 65536;
  localparam int MAX_WIDTH = 64;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  function automatic int calc_aw(input int depth);
    return clog2(depth);
  endfunction

  // One extra bit so that a completely full FIFO (COUNT == DEPTH) is representable.
  function automatic int calc_cw(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int afval, input int aeval);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) && is_pow2(depth) &&
           (aeval >= 0) && (aeval < afval) && (afval <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// Simple dual-port RAM, WIDTH x DEPTH, single clock, registered read data.
// Kept as its own module so a vendor RAM macro can be dropped in unchanged.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; rdata loads mem[raddr] on the edge
//   raddr  - read address
//   rdata  - registered read data (holds when re = 0)
// -----------------------------------------------------------------------------
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO with programmable almost-full /
// almost-empty thresholds, occupancy count, error flags and synchronous flush.
//
// Datapath: RAM (registered read) -> p1 (RAM rdata) -> p2 (output register Q).
// A word written at edge N is visible on Q after edge N+2; with two words
// prefetched, back-to-back pops run at one word per cycle.
//
// Ports:
//   CLK       - clock, rising edge
//   RESET     - synchronous active-high reset (priority over everything)
//   FLUSH     - synchronous clear of FIFO state; WE/RE ignored that cycle
//   WE, DATA  - write request and data
//   RE        - pop request
//   ERR_CLR   - clears sticky error flags (only with SYNC_FIFO_STICKY_ERR_EN)
//   Q         - head word, valid while EMPTY = 0
//   FULL      - COUNT == DEPTH
//   EMPTY     - no valid word on Q
//   AFULL     - COUNT >= AFVAL
//   AEMPTY    - COUNT <= AEVAL
//   COUNT     - occupancy including the word held on Q
//   OVERFLOW  - write rejected because full
//   UNDERFLOW - pop requested while empty
//
// Macro SYNC_FIFO_STICKY_ERR_EN: when defined OVERFLOW/UNDERFLOW are sticky
// levels cleared by RESET, FLUSH or ERR_CLR (a new set wins over ERR_CLR);
// when undefined they are one-cycle pulses and ERR_CLR does not exist.
// -----------------------------------------------------------------------------
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  parameter int AFVAL = DEPTH - 4,
  parameter int AEVAL = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      FLUSH,
  input  logic                      WE,
  input  logic [WIDTH-1:0]          DATA,
  input  logic                      RE,
`ifdef SYNC_FIFO_STICKY_ERR_EN
  input  logic                      ERR_CLR,
`endif
  output logic [WIDTH-1:0]          Q,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic                      AFULL,
  output logic                      AEMPTY,
  output logic [calc_cw(DEPTH)-1:0] COUNT,
  output logic                      OVERFLOW,
  output logic                      UNDERFLOW
);

  localparam int AW = calc_aw(DEPTH);
  localparam int CW = calc_cw(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFVAL);
  localparam logic [CW-1:0] AE_C    = CW'(AEVAL);

  if (!params_ok(WIDTH, DEPTH, AFVAL, AEVAL)) begin : g_bad_params
    $error("sync_fifo_fwft: illegal WIDTH/DEPTH/AFVAL/AEVAL combination");
  end

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic [CW-1:0]    held;
  logic             full_r;
  logic             afull_r;
  logic             aempty_r;
  logic             ovf_r;
  logic             unf_r;

  logic             clr;
  logic             pop;
  logic             wr;
  logic             rd_ram;
  logic             ld_p2;
  logic             ovf_set;
  logic             unf_set;

  logic [WIDTH-1:0] rdata_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] q_p2;
  logic             vld_p2;

  always_comb begin
    clr     = RESET | FLUSH;
    pop     = RE & vld_p2 & ~clr;
    wr      = WE & (~full_r | pop) & ~clr;
    // Words already pulled out of the RAM into p1/p2 are part of COUNT;
    // whatever is left over still sits in the RAM.
    held    = CW'(vld_p1) + CW'(vld_p2);
    ld_p2   = vld_p1 & (~vld_p2 | pop);
    rd_ram  = (count > held) & (~vld_p1 | ld_p2) & ~clr;
    ovf_set = WE & full_r & ~pop & ~clr;
    unf_set = RE & ~vld_p2 & ~clr;
    count_n = count;
    unique case ({wr, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // Control state: pointers, occupancy, stage valids, registered flags
  always_ff @(posedge CLK) begin
    if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
    end else begin
      if (wr) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_ram) begin
        rptr <= rptr + AW'(1);
      end
      count    <= count_n;
      vld_p1   <= rd_ram | (vld_p1 & ~ld_p2);
      vld_p2   <= (vld_p2 & ~pop) | vld_p1;
      full_r   <= (count_n == DEPTH_C);
      afull_r  <= (count_n >= AF_C);
      aempty_r <= (count_n <= AE_C);
    end
  end

  // Error flags
  always_ff @(posedge CLK) begin
    if (clr) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
`ifdef SYNC_FIFO_STICKY_ERR_EN
      ovf_r <= ovf_set | (ovf_r & ~ERR_CLR);
      unf_r <= unf_set | (unf_r & ~ERR_CLR);
`else
      ovf_r <= ovf_set;
      unf_r <= unf_set;
`endif
    end
  end

  // Stage p0 -> p1: RAM write port and registered RAM read
  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (wr),
    .waddr (wptr),
    .wdata (DATA),
    .re    (rd_ram),
    .raddr (rptr),
    .rdata (rdata_p1)
  );

  // Stage p1 -> p2: FWFT output register (cleared so Q reads 0 after reset)
  always_ff @(posedge CLK) begin
    if (clr) begin
      q_p2 <= '0;
    end else if (ld_p2) begin
      q_p2 <= rdata_p1;
    end
  end

  assign Q         = q_p2;
  assign EMPTY     = ~vld_p2;
  assign FULL      = full_r;
  assign AFULL     = afull_r;
  assign AEMPTY    = aempty_r;
  assign COUNT     = count;
  assign OVERFLOW  = ovf_r;
  assign UNDERFLOW = unf_r;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_fwft
// Self-checking bench for sync_fifo_fwft (default parameters). A queue-based
// reference model tracks contents, occupancy and when each head word becomes
// visible on Q (two edges after its write, never before the previous pop).
// -----------------------------------------------------------------------------
module tb_sync_fifo_fwft;
  import sync_fifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4096;
  localparam int AFVAL = DEPTH - 4;
  localparam int AEVAL = 4;
  localparam int CW    = calc_cw(DEPTH);

  logic             CLK;
  logic             RESET;
  logic             FLUSH;
  logic             WE;
  logic [WIDTH-1:0] DATA;
  logic             RE;
`ifdef SYNC_FIFO_STICKY_ERR_EN
  logic             ERR_CLR;
`endif
  logic [WIDTH-1:0] Q;
  logic             FULL;
  logic             EMPTY;
  logic             AFULL;
  logic             AEMPTY;
  logic [CW-1:0]    COUNT;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  sync_fifo_fwft #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AFVAL (AFVAL),
    .AEVAL (AEVAL)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (FLUSH),
    .WE        (WE),
    .DATA      (DATA),
    .RE        (RE),
`ifdef SYNC_FIFO_STICKY_ERR_EN
    .ERR_CLR   (ERR_CLR),
`endif
    .Q         (Q),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .AFULL     (AFULL),
    .AEMPTY    (AEMPTY),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  int               mw[$];
  int               last_pop = -100;
  int               ecnt     = 0;
  bit               ovf_m    = 1'b0;
  bit               unf_m    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  // Head is on Q once it has been in the FIFO for two edges and the word
  // ahead of it has been popped.
  function automatic bit model_empty_at(input int e);
    int vis;
    if (mq.size() == 0) return 1'b1;
    vis = mw[0] + 2;
    if (last_pop > vis) vis = last_pop;
    return !(e >= vis);
  endfunction

  task automatic model_edge();
    bit empty_b, full_b, pop, wr, ovf_set, unf_set;
    ecnt++;
    if (RESET || FLUSH) begin
      mq.delete();
      mw.delete();
      last_pop = -100;
      ovf_m    = 1'b0;
      unf_m    = 1'b0;
    end else begin
      empty_b = model_empty_at(ecnt - 1);
      full_b  = (mq.size() == DEPTH);
      pop     = RE && !empty_b;
      wr      = WE && (!full_b || pop);
      ovf_set = WE && full_b && !pop;
      unf_set = RE && empty_b;
      if (pop) begin
        void'(mq.pop_front());
        void'(mw.pop_front());
        last_pop = ecnt;
      end
      if (wr) begin
        mq.push_back(DATA);
        mw.push_back(ecnt);
      end
`ifdef SYNC_FIFO_STICKY_ERR_EN
      ovf_m = ovf_set || (ovf_m && !ERR_CLR);
      unf_m = unf_set || (unf_m && !ERR_CLR);
`else
      ovf_m = ovf_set;
      unf_m = unf_set;
`endif
    end
  endtask

  task automatic check_outputs();
    int  cnt;
    bit  emp;
    cnt = mq.size();
    emp = model_empty_at(ecnt);
    chk("count",     32'(COUNT),     32'(cnt));
    chk("full",      32'(FULL),      32'(cnt == DEPTH));
    chk("afull",     32'(AFULL),     32'(cnt >= AFVAL));
    chk("aempty",    32'(AEMPTY),    32'(cnt <= AEVAL));
    chk("empty",     32'(EMPTY),     32'(emp));
    chk("overflow",  32'(OVERFLOW),  32'(ovf_m));
    chk("underflow", 32'(UNDERFLOW), 32'(unf_m));
    if (!emp) chk("q", 32'(Q), 32'(mq[0]));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic rand_cycles(input int n, input int we_pct, input int re_pct);
    for (int i = 0; i < n; i++) begin
      WE   = ($urandom_range(0, 99) < we_pct);
      RE   = ($urandom_range(0, 99) < re_pct);
      DATA = WIDTH'($urandom);
      tick();
    end
    WE = 1'b0;
    RE = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    FLUSH = 1'b0;
    WE    = 1'b0;
    RE    = 1'b0;
    DATA  = '0;
`ifdef SYNC_FIFO_STICKY_ERR_EN
    ERR_CLR = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_q", 32'(Q), 32'h0);
    RESET = 1'b0;

    // Write 0x01..0x05 back to back, then continuous reads
    for (int i = 1; i <= 5; i++) begin
      WE   = 1'b1;
      DATA = WIDTH'(i);
      tick();
      if (i == 2) chk("lat_empty_n1", 32'(EMPTY), 32'h1);
      if (i == 3) chk("lat_q_n2", 32'(Q), 32'h01);
    end
    WE = 1'b0;
    tick();
    chk("count5", 32'(COUNT), 32'd5);
    RE = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("burst_q", 32'(Q), 32'(i));
      tick();
    end
    RE = 1'b0;
    chk("drained_empty", 32'(EMPTY), 32'h1);

    // Pop on empty: underflow, state unchanged
    RE = 1'b1;
    tick();
    chk("unf_pulse", 32'(UNDERFLOW), 32'h1);
    RE = 1'b0;
    tick();
    tick();
`ifdef SYNC_FIFO_STICKY_ERR_EN
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    tick();
`endif

    // Fill to DEPTH, then one rejected write
    for (int i = 0; i < DEPTH; i++) begin
      WE   = 1'b1;
      DATA = WIDTH'($urandom);
      tick();
    end
    chk("full_at_depth", 32'(FULL), 32'h1);
    DATA = 8'hEE;
    tick();
    chk("ovf_pulse", 32'(OVERFLOW), 32'h1);

    // Simultaneous write and pop while full
    RE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      DATA = WIDTH'($urandom);
      tick();
      chk("full_rw_count", 32'(COUNT), 32'(DEPTH));
    end
    WE = 1'b0;

    // Drain everything, crossing the pointer wrap
    repeat (DEPTH + 4) tick();
    RE = 1'b0;
`ifdef SYNC_FIFO_STICKY_ERR_EN
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
`endif

    // Random traffic at several fill biases
    rand_cycles(800, 50, 50);
    rand_cycles(800, 70, 40);
    rand_cycles(800, 30, 70);

    // COUNT = 100, then flush with WE/RE active
    RE = 1'b1;
    repeat (40) tick();
    RE = 1'b0;
    for (int i = 0; i < 100; i++) begin
      WE   = 1'b1;
      DATA = WIDTH'($urandom);
      tick();
    end
    WE = 1'b0;
    chk("count100", 32'(COUNT), 32'd100);
    FLUSH = 1'b1;
    WE    = 1'b1;
    RE    = 1'b1;
    tick();
    FLUSH = 1'b0;
    RE    = 1'b0;
    chk("flush_count", 32'(COUNT), 32'd0);
    chk("flush_empty", 32'(EMPTY), 32'h1);
    DATA = 8'hA5;
    tick();
    WE = 1'b0;
    repeat (2) tick();
    chk("flush_a5", 32'(Q), 32'hA5);

    // Reset in the middle of a burst
    rand_cycles(60, 80, 40);
    WE    = 1'b1;
    RE    = 1'b1;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    WE    = 1'b0;
    RE    = 1'b0;
    chk("midrst_q", 32'(Q), 32'h0);
    chk("midrst_count", 32'(COUNT), 32'd0);
    tick();
    chk("midrst_empty", 32'(EMPTY), 32'h1);
    rand_cycles(300, 60, 50);

    // Random traffic with occasional flush
    for (int i = 0; i < 600; i++) begin
      WE    = ($urandom_range(0, 99) < 55);
      RE    = ($urandom_range(0, 99) < 50);
      FLUSH = ($urandom_range(0, 63) == 0);
      DATA  = WIDTH'($urandom);
      tick();
    end
    FLUSH = 1'b0;
    WE    = 1'b0;
    RE    = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
